// File: rtl/ram_write_manager.sv
// Per-input event writer: captures an L-sample window on trigger into the ring-buffer RAM.
// Optional WM_EVENT_STAMP_EN: replaces the last word of each window with the n_done count.
module ram_write_manager #(
    parameter int MAX_NEVENT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    live_rising,
    input  logic                    input_ena,
    input  logic                    trigger,
    input  logic [15:0]             din,
    input  logic [9:0]              HALF_PACKAGE_LENGTH,
    input  logic [13:0]             MEMORY_DEPTH,
    input  logic [MAX_NEVENT_W-1:0] MAX_NEVENT,
    input  logic [15:0]             n_read,
    output logic                    wen,
    output logic [13:0]             waddr,
    output logic [15:0]             wdata,
    output logic                    w_complete,
    output logic [15:0]             n_done,
    output logic                    busy,
    output logic                    retrig_err,
    output logic                    overflow,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state;
    logic [13:0] init_addr;
    logic [9:0]  cnt;
    logic [14:0] init_sum;
    logic [15:0] outstanding;
    logic [13:0] next_addr;

    // The init_addr sum is 15 bits wide so L + init_addr never wraps before the depth compare.
    always_comb begin
        init_sum    = {1'b0, init_addr} + {5'b0, HALF_PACKAGE_LENGTH};
        outstanding = n_done - n_read;
        next_addr   = (waddr == MEMORY_DEPTH - 14'd1) ? 14'd0 : waddr + 14'd1;
    end

    assign busy = (state != IDLE);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || live_rising) begin
            state      <= IDLE;
            init_addr  <= '0;
            cnt        <= '0;
            wen        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            w_complete <= 1'b0;
            n_done     <= '0;
            retrig_err <= 1'b0;
            overflow   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wen        <= 1'b0;
                    w_complete <= 1'b0;
                    if (trigger && input_ena) begin
                        if (HALF_PACKAGE_LENGTH == 10'd0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state <= WRITE;
                            wen   <= 1'b1;
                            waddr <= init_addr;
                            cnt   <= 10'd1;
`ifdef WM_EVENT_STAMP_EN
                            wdata <= (HALF_PACKAGE_LENGTH == 10'd1) ? n_done : din;
`else
                            wdata <= din;
`endif
                            if (32'(outstanding) >= 32'(MAX_NEVENT))
                                overflow <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (trigger)
                        retrig_err <= 1'b1;
                    if (cnt == HALF_PACKAGE_LENGTH) begin
                        state      <= DONE;
                        wen        <= 1'b0;
                        w_complete <= 1'b1;
                    end else begin
                        wen   <= 1'b1;
                        waddr <= next_addr;
                        cnt   <= cnt + 10'd1;
`ifdef WM_EVENT_STAMP_EN
                        // Final word of the window carries the pre-increment event count.
                        wdata <= (cnt == HALF_PACKAGE_LENGTH - 10'd1) ? n_done : din;
`else
                        wdata <= din;
`endif
                    end
                end
                DONE: begin
                    if (trigger)
                        retrig_err <= 1'b1;
                    state      <= IDLE;
                    w_complete <= 1'b0;
                    n_done     <= n_done + 16'd1;
                    cnt        <= '0;
                    if (init_sum >= {1'b0, MEMORY_DEPTH})
                        init_addr <= 14'(init_sum - {1'b0, MEMORY_DEPTH});
                    else
                        init_addr <= init_sum[13:0];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
